// File: rtl/dsp_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mul_pkg
// Purpose  : Shared OPMODE encodings, sequencer state type and widths.
// Revision : 1.0
// ============================================================================
package dsp_mul_pkg;

    localparam int OPM_W  = 7;
    localparam int WORD_W = 17;

    localparam logic [OPM_W-1:0] OPM_IDLE    = 7'b000_0000;
    localparam logic [OPM_W-1:0] OPM_M       = 7'b000_0101;
    localparam logic [OPM_W-1:0] OPM_M_ACC   = 7'b010_0101;
    localparam logic [OPM_W-1:0] OPM_M_SHIFT = 7'b110_0101;
    localparam logic [OPM_W-1:0] OPM_SHIFT   = 7'b110_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : seq_delay_line
// Purpose  : Reset-clearable shift register; DEPTH=0 is a plain wire.
// Revision : 1.0
// ============================================================================
module seq_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_wire
        assign data_o = data_i;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clock_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            end else begin
                r_stage[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign data_o = r_stage[DEPTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/dsp_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mul_sequencer
// Purpose  : Column-wise (product-scanning) schedule for one 17x17 DSP slice.
// Revision : 1.0
// ============================================================================
module dsp_mul_sequencer
    import dsp_mul_pkg::*;
#(
    parameter int WORD_COUNT = 4,
    parameter int ABREG      = 1,
    parameter int MREG       = 1
) (
    input  logic                            clock_i,
    input  logic                            rst_n_i,
    input  logic                            start_i,
    output logic                            ready_o,
    output logic [$clog2(WORD_COUNT)-1:0]   a_idx_o,
    output logic [$clog2(WORD_COUNT)-1:0]   b_idx_o,
    output logic [OPM_W-1:0]                opmode_o,
    output logic                            word_valid_o,
    output logic [$clog2(2*WORD_COUNT)-1:0] word_idx_o,
    output logic                            done_o
);

    localparam int IDX_W  = $clog2(WORD_COUNT);
    localparam int COL_W  = $clog2(2*WORD_COUNT);
    localparam int LAT    = ABREG + MREG;
    localparam int FLAG_W = COL_W + 2;

    localparam logic [COL_W-1:0] c_top_j     = COL_W'(WORD_COUNT - 1);
    localparam logic [COL_W-1:0] c_last_col  = COL_W'(2*WORD_COUNT - 2);
    localparam logic [COL_W-1:0] c_carry_idx = COL_W'(2*WORD_COUNT - 1);

    if (LAT < 1) begin : g_bad_latency
        $error("dsp_mul_sequencer: ABREG+MREG must be at least 1");
    end
    if (WORD_COUNT < 2 || WORD_COUNT > 16) begin : g_bad_word_count
        $error("dsp_mul_sequencer: WORD_COUNT must be in 2..16");
    end

    function automatic logic [IDX_W-1:0] j_lo(input logic [COL_W-1:0] col);
        return (col > c_top_j) ? IDX_W'(col - c_top_j) : '0;
    endfunction

    function automatic logic [IDX_W-1:0] j_hi(input logic [COL_W-1:0] col);
        return (col >= c_top_j) ? IDX_W'(c_top_j) : IDX_W'(col);
    endfunction

    seq_state_t        r_state;
    logic [COL_W-1:0]  r_col;
    logic [IDX_W-1:0]  r_j;
    logic              r_carry;
    logic [IDX_W-1:0]  r_a_idx;
    logic [IDX_W-1:0]  r_b_idx;
    logic [OPM_W-1:0]  r_opm_pre;
    logic [FLAG_W-1:0] r_flag_pre;

    logic              w_load;
    logic              w_carry;
    logic [COL_W-1:0]  w_col;
    logic [IDX_W-1:0]  w_j;
    logic [IDX_W-1:0]  w_b;
    logic [OPM_W-1:0]  w_opm;
    logic [FLAG_W-1:0] w_flag;
    logic [FLAG_W-1:0] w_flag_out;

    // Select the slot to present next cycle: first term of a new run, next
    // term of the current column, first term of the next column, or carry.
    always_comb begin
        w_load  = 1'b0;
        w_carry = 1'b0;
        w_col   = r_col;
        w_j     = r_j;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_load = 1'b1;
                    w_col  = '0;
                    w_j    = '0;
                end
            end
            ST_ISSUE: begin
                if (!r_carry) begin
                    w_load = 1'b1;
                    if (r_j != j_hi(r_col)) begin
                        w_j = r_j + 1'b1;
                    end else if (r_col == c_last_col) begin
                        w_carry = 1'b1;
                    end else begin
                        w_col = r_col + 1'b1;
                        w_j   = j_lo(r_col + 1'b1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_b = IDX_W'(w_col - COL_W'(w_j));
        if (w_carry) begin
            w_opm  = OPM_SHIFT;
            w_flag = {1'b1, c_carry_idx, 1'b1};
        end else begin
            if (w_j != j_lo(w_col))   w_opm = OPM_M_ACC;
            else if (w_col == '0)     w_opm = OPM_M;
            else                      w_opm = OPM_M_SHIFT;
            w_flag = {(w_j == j_hi(w_col)), w_col, 1'b0};
        end
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_j        <= '0;
            r_carry    <= 1'b0;
            r_a_idx    <= '0;
            r_b_idx    <= '0;
            r_opm_pre  <= OPM_IDLE;
            r_flag_pre <= '0;
        end else begin
            if (w_load) begin
                r_col      <= w_col;
                r_j        <= w_j;
                r_carry    <= w_carry;
                r_a_idx    <= w_carry ? '0 : w_j;
                r_b_idx    <= w_carry ? '0 : w_b;
                r_opm_pre  <= w_opm;
                r_flag_pre <= w_flag;
            end else begin
                r_a_idx    <= '0;
                r_b_idx    <= '0;
                r_opm_pre  <= OPM_IDLE;
                r_flag_pre <= '0;
            end
            case (r_state)
                ST_IDLE:  if (start_i)    r_state <= ST_ISSUE;
                ST_ISSUE: if (r_carry)    r_state <= ST_DRAIN;
                ST_DRAIN: if (w_flag_out[0]) r_state <= ST_IDLE;
                default:                  r_state <= ST_IDLE;
            endcase
        end
    end

    // Opmode must reach the DSP one cycle before its product does.
    seq_delay_line #(.WIDTH(OPM_W), .DEPTH(LAT - 1)) u_opm_dly (
        .clock_i (clock_i),
        .rst_n_i (rst_n_i),
        .data_i  (r_opm_pre),
        .data_o  (opmode_o)
    );

    seq_delay_line #(.WIDTH(FLAG_W), .DEPTH(LAT + 1)) u_flag_dly (
        .clock_i (clock_i),
        .rst_n_i (rst_n_i),
        .data_i  (r_flag_pre),
        .data_o  (w_flag_out)
    );

    assign ready_o      = (r_state == ST_IDLE);
    assign a_idx_o      = r_a_idx;
    assign b_idx_o      = r_b_idx;
    assign word_valid_o = w_flag_out[FLAG_W-1];
    assign word_idx_o   = w_flag_out[FLAG_W-2:1];
    assign done_o       = w_flag_out[0];

endmodule
`default_nettype wire

// File: doc/dsp_mul_sequencer.md
# dsp_mul_sequencer

Sequencer that drives a single cascadable 17x17 DSP slice through a product-scanning (column-wise) multiplication of two WORD_COUNT-word operands in radix 2^17. It issues operand word indices to the operand muxes feeding A_i/B_i, and issues the matching OPMODE_i one pipeline stage later. It flags each 17-bit result word as it appears on P_o[16:0]. It sits between the FIOS top-level control and one DSP instance, and is the building block for later multi-DSP schedulers.

## Interface
- WORD_COUNT, 4: operand length S in 17-bit words; legal 2..16, so column sums stay below 2^39 and fit the 48-bit P.
- ABREG, 1: must equal the DSP's ABREG.
- MREG, 1: must equal the DSP's MREG. ABREG+MREG must be ≥1; elaboration error otherwise.
- clock_i  in  1  rising-edge clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  start request; accepted only when ready_o=1.
- ready_o  out  1  idle and able to accept start_i.
- a_idx_o  out  $clog2(S)  index j of the A operand word to present on DSP A_i this cycle.
- b_idx_o  out  $clog2(S)  index of the B operand word to present on DSP B_i this cycle.
- opmode_o  out  7  drives DSP OPMODE_i directly.
- word_valid_o  out  1  P_o[16:0] holds result word word_idx_o this cycle.
- word_idx_o  out  $clog2(2S)  result word index, 0..2S-1.
- done_o  out  1  one-cycle pulse coincident with the final word_valid_o.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: ready_o=1.
  - start_i=1 → ISSUE on the next edge.
  - start_i is ignored in ISSUE and DRAIN.
- ISSUE runs columns k=0..2S-2, then one carry slot.
  - Column k issues terms j=max(0,k-S+1)..min(k,S-1), in ascending j.
  - Each term drives a_idx_o=j and b_idx_o=k-j.
  - Total issue slots: S^2+1.
- Opmode per term, one per issue slot:
  - First term of column 0: 7'b000_0101 (XY=M, Z=0).
  - First term of columns k>0: 7'b110_0101 (XY=M, Z=P>>17).
  - Other terms: 7'b010_0101 (XY=M, Z=P).
  - Carry slot: 7'b110_0000 (XY=0, Z=P>>17). Index outputs are don't-care during this slot and are driven 0.
- Outside scheduled slots, opmode_o=7'b000_0000.
- Result word k is P[16:0] after the last term of column k; word 2S-1 is P[16:0] after the carry slot.
- DRAIN: waits out the pipeline, then returns to IDLE in the cycle after done_o.
- Reset (any time, including mid-operation), asynchronous:
  - State → IDLE, ready_o=1.
  - Counters and all delay-line contents → 0.
  - word_valid_o=0, done_o=0, opmode_o=0, a_idx_o=0, b_idx_o=0, word_idx_o=0.
- The DSP's own P is not cleared by this block. The column-0 opmode discards any stale P.

## Timing
- start_i accepted in cycle 0 → first issue slot in cycle 1 → last slot in cycle S^2+1. No bubbles between slots.
- The index of an issue slot is valid in cycle t.
- opmode_o for that slot is driven in cycle t+ABREG+MREG-1, which is when the DSP samples OPMODE_i for alignment with M.
- P for that slot is valid in cycle t+ABREG+MREG+1. The word_valid_o/word_idx_o for a column-final slot assert in this cycle.
- done_o in cycle S^2+1+ABREG+MREG+1; ready_o=1 from the following cycle.
- With defaults (S=4, ABREG=MREG=1): done_o in cycle 20.
- Back-to-back: a start_i held high is re-accepted in the first ready_o cycle. The new column-0 opmode overwrites the old P, so no gap is required.

## Structure
- Package dsp_mul_pkg holds:
  - OPMODE constants: OPM_IDLE, OPM_M, OPM_M_ACC, OPM_M_SHIFT, OPM_SHIFT.
  - State enum.
  - Width helper localparams.
- One sub-module, seq_delay_line #(WIDTH, DEPTH). It is a reset-clearable shift register.
  - Instance 1: DEPTH=ABREG+MREG-1, for opmode.
  - Instance 2: DEPTH=ABREG+MREG+1, for {word_valid, word_idx, done}.
  - DEPTH=0 degenerates to a wire.

## Test plan
- S=2, A=1, B=1 (words [1,0]):
  - Issue order (a,b) = (0,0), (0,1), (1,0), (1,1), carry.
  - Words 0x00001, 0, 0, 0.
  - done_o in cycle 8.
- S=2, A=B=2^34-1 → words 0x00001, 0x00000, 0x1FFFE, 0x1FFFF. This exercises the carry shift and carry slot.
- S=4, all words 0x1FFFF on both operands:
  - 8 words equal the 136-bit product (2^68-1)^2.
  - word_valid_o pulses at the cycles given by the column-end formula.
- start_i pulsed while busy → ignored. The opmode trace is identical to a single run, and there is exactly one done_o.
- rst_n_i low mid-ISSUE:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, start_i gives a clean, correct result.
- ABREG=0, MREG=1 and ABREG=1, MREG=0:
  - opmode_o aligns in cycle t+0.
  - P/word timing is at t+2.
  - Products match the reference model.
